adapter_pad_sched: RTL and testbench

- Sequencing controller for the BCEDN adapter front end.
- Walks one H x W input plane in raster order over the zero-padded (H+2*PAD) x (W+2*PAD) grid.
- Drives the pad mux and line-buffer write strobe, and stalls the pixel source on padding positions.
- Flags each position that completes an FH x FW window at the configured stride. These flags feed the downstream EC block.

---
 rtl/adapter_pkg.sv | 44 ++++
 rtl/adapter_pad_sched_raster_stride_cnt.sv | 57 +++++
 rtl/adapter_pad_sched.sv | 121 ++++++++++++
 tb/tb_adapter_pad_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adapter_pkg.sv
// Shared types and size helpers for the adapter pad scheduler.
// Padded-grid and window-count math lives here so counter and controller agree.
package adapter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // Never returns less than 1 so degenerate sizes still give a legal vector.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int padded(input int n, input int pad);
        return n + 2 * pad;
    endfunction

    function automatic int win_count(input int np, input int f, input int s);
        return (np - f) / s + 1;
    endfunction

    function automatic int last_win_pos(input int np, input int f, input int s);
        return (f - 1) + (win_count(np, f, s) - 1) * s;
    endfunction

    localparam int DEF_H        = 32;
    localparam int DEF_W        = 32;
    localparam int DEF_PAD      = 1;
    localparam int DEF_FH       = 3;
    localparam int DEF_FW       = 3;
    localparam int DEF_STRIDE_H = 1;
    localparam int DEF_STRIDE_W = 1;
    localparam int HP           = padded(DEF_H, DEF_PAD);
    localparam int WP           = padded(DEF_W, DEF_PAD);
    localparam int WIN_PER_ROW  = win_count(WP, DEF_FW, DEF_STRIDE_W);
    localparam int WIN_ROWS     = win_count(HP, DEF_FH, DEF_STRIDE_H);

endpackage

// File: rtl/adapter_pad_sched_raster_stride_cnt.sv
// 2-D raster wrap counter over the padded grid, with stride phases that
// start counting once a full window fits in that dimension.
module raster_stride_cnt import adapter_pkg::*; #(
    parameter int HP       = 34,
    parameter int WP       = 34,
    parameter int FH       = 3,
    parameter int FW       = 3,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1,
    parameter int RW       = clog2(HP),
    parameter int CW       = clog2(WP),
    parameter int RPW      = clog2(STRIDE_H),
    parameter int CPW      = clog2(STRIDE_W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           adv,
    output logic [RW-1:0]  row,
    output logic [CW-1:0]  col,
    output logic [RPW-1:0] rph,
    output logic [CPW-1:0] cph,
    output logic           row_end,
    output logic           frame_end
);

    assign row_end   = (int'(col) == WP - 1);
    assign frame_end = row_end && (int'(row) == HP - 1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
            rph <= '0;
            cph <= '0;
        end else if (adv) begin
            if (row_end) begin
                col <= '0;
                cph <= '0;
                if (frame_end) begin
                    row <= '0;
                    rph <= '0;
                end else begin
                    row <= row + 1'b1;
                    // Phase stays 0 until the first full window row is reached.
                    if (int'(row) >= FH - 1)
                        rph <= (int'(rph) >= STRIDE_H - 1) ? '0 : rph + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
                if (int'(col) >= FW - 1)
                    cph <= (int'(cph) >= STRIDE_W - 1) ? '0 : cph + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adapter_pad_sched.sv
// Frame sequencer: walks the zero-padded grid, stalls the source on pad
// positions and flags completed windows for the downstream EC block.
module adapter_pad_sched import adapter_pkg::*; #(
    parameter int H        = 32,
    parameter int W        = 32,
    parameter int PAD      = 1,
    parameter int FH       = 3,
    parameter int FW       = 3,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1,
    parameter int P        = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_en,
    output logic                           in_rdy,
    output logic                           pad_mux_sel,
    output logic                           wr_en,
    output logic [clog2(H+2*PAD)-1:0]      row_cnt,
    output logic [clog2(W+2*PAD)-1:0]      col_cnt,
    output logic                           win_valid,
    output logic                           tg_next,
    output logic                           busy,
    output logic                           done
);

    localparam int HPL          = padded(H, PAD);
    localparam int WPL          = padded(W, PAD);
    localparam int LAST_WIN_COL = last_win_pos(WPL, FW, STRIDE_W);
    localparam int RPW          = clog2(STRIDE_H);
    localparam int CPW          = clog2(STRIDE_W);
    localparam int GW           = clog2(P + 1);

    state_t          state;
    logic [GW-1:0]   gap_cnt;
    logic [RPW-1:0]  rph;
    logic [CPW-1:0]  cph;
    logic            row_end;
    logic            frame_end;
    logic            scan;
    logic            pad_pos;
    logic            at_window;
    logic            frame_start;

    assign scan        = (state == S_SCAN);
    assign frame_start = (state == S_IDLE) && start;

    // Pad decode uses only the registered position, never the source valid.
    assign pad_pos = (int'(row_cnt) < PAD) || (int'(row_cnt) >= H + PAD) ||
                     (int'(col_cnt) < PAD) || (int'(col_cnt) >= W + PAD);

    assign pad_mux_sel = scan && pad_pos;
    assign in_rdy      = scan && !pad_pos;
    assign wr_en       = scan && (pad_pos || in_en);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FIN);

    assign at_window = (int'(row_cnt) >= FH - 1) && (int'(col_cnt) >= FW - 1) &&
                       (rph == '0) && (cph == '0);

    raster_stride_cnt #(
        .HP       (HPL),
        .WP       (WPL),
        .FH       (FH),
        .FW       (FW),
        .STRIDE_H (STRIDE_H),
        .STRIDE_W (STRIDE_W),
        .RW       (clog2(H+2*PAD)),
        .CW       (clog2(W+2*PAD)),
        .RPW      (RPW),
        .CPW      (CPW)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start),
        .adv       (wr_en),
        .row       (row_cnt),
        .col       (col_cnt),
        .rph       (rph),
        .cph       (cph),
        .row_end   (row_end),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            win_valid <= 1'b0;
            tg_next   <= 1'b0;
        end else begin
            win_valid <= wr_en && at_window;
            tg_next   <= wr_en && at_window && (int'(col_cnt) == LAST_WIN_COL);
            case (state)
                S_IDLE: begin
                    if (start) state <= S_SCAN;
                end
                S_SCAN: begin
                    if (wr_en) begin
                        if (frame_end) begin
                            state <= S_FIN;
                        end else if (row_end && (P > 0)) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (int'(gap_cnt) >= P - 1) state <= S_SCAN;
                    else                        gap_cnt <= gap_cnt + 1'b1;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adapter_pad_sched.sv
// Bench for adapter_pad_sched: three configurations checked cycle by cycle
// against a raster-order position model derived from the grid rules.
module tb_adapter_pad_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_s = '0;
    logic [2:0] in_en_s = '0;
    logic [2:0] rdy_s, pad_s, wr_s, win_s, tg_s, busy_s, done_s;
    logic [2:0] row_a, col_a, row_b, col_b;
    logic [1:0] row_c, col_c;

    // Configuration table: index 0 = 4x4 pad1, 1 = 6x6 stride2, 2 = 3x3 no pad.
    int cfg_h   [3] = '{4, 6, 3};
    int cfg_w   [3] = '{4, 6, 3};
    int cfg_pad [3] = '{1, 1, 0};
    int cfg_fh  [3] = '{3, 3, 3};
    int cfg_fw  [3] = '{3, 3, 3};
    int cfg_sh  [3] = '{1, 2, 1};
    int cfg_sw  [3] = '{1, 2, 1};
    int cfg_p   [3] = '{1, 1, 0};

    int n_tests = 0;
    int n_fail  = 0;

    // Observed per-frame statistics.
    int obs_wr, obs_pad, obs_win, obs_tg, obs_rdy_pad, consumed, stalls, done_cyc;

    always #5 clk = ~clk;

    adapter_pad_sched #(.H(4), .W(4), .PAD(1), .FH(3), .FW(3),
                        .STRIDE_H(1), .STRIDE_W(1), .P(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .in_en(in_en_s[0]),
        .in_rdy(rdy_s[0]), .pad_mux_sel(pad_s[0]), .wr_en(wr_s[0]),
        .row_cnt(row_a), .col_cnt(col_a), .win_valid(win_s[0]),
        .tg_next(tg_s[0]), .busy(busy_s[0]), .done(done_s[0]));

    adapter_pad_sched #(.H(6), .W(6), .PAD(1), .FH(3), .FW(3),
                        .STRIDE_H(2), .STRIDE_W(2), .P(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .in_en(in_en_s[1]),
        .in_rdy(rdy_s[1]), .pad_mux_sel(pad_s[1]), .wr_en(wr_s[1]),
        .row_cnt(row_b), .col_cnt(col_b), .win_valid(win_s[1]),
        .tg_next(tg_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    adapter_pad_sched #(.H(3), .W(3), .PAD(0), .FH(3), .FW(3),
                        .STRIDE_H(1), .STRIDE_W(1), .P(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_s[2]), .in_en(in_en_s[2]),
        .in_rdy(rdy_s[2]), .pad_mux_sel(pad_s[2]), .wr_en(wr_s[2]),
        .row_cnt(row_c), .col_cnt(col_c), .win_valid(win_s[2]),
        .tg_next(tg_s[2]), .busy(busy_s[2]), .done(done_s[2]));

    function automatic logic [31:0] row_of(input int k);
        case (k)
            0:       return 32'(row_a);
            1:       return 32'(row_b);
            default: return 32'(row_c);
        endcase
    endfunction

    function automatic logic [31:0] col_of(input int k);
        case (k)
            0:       return 32'(col_a);
            1:       return 32'(col_b);
            default: return 32'(col_c);
        endcase
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cfg %0d): observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int k);
        check({tag, ".wr_en"},       k, 32'(wr_s[k]),   0);
        check({tag, ".pad_mux_sel"}, k, 32'(pad_s[k]),  0);
        check({tag, ".in_rdy"},      k, 32'(rdy_s[k]),  0);
        check({tag, ".win_valid"},   k, 32'(win_s[k]),  0);
        check({tag, ".tg_next"},     k, 32'(tg_s[k]),   0);
        check({tag, ".busy"},        k, 32'(busy_s[k]), 0);
        check({tag, ".done"},        k, 32'(done_s[k]), 0);
        check({tag, ".row_cnt"},     k, row_of(k),      0);
        check({tag, ".col_cnt"},     k, col_of(k),      0);
    endtask

    // Runs one frame on configuration k. stall randomizes in_en, noise pulses
    // start while busy, rst_at >= 0 fires a reset at that raster index.
    task automatic run_frame(input int k, input bit stall, input bit noise,
                             input int rst_at);
        int hp, wp, n, idx, gap, cyc, r, c;
        bit pend_w, pend_t, pad, wr, got_done;
        hp = cfg_h[k] + 2 * cfg_pad[k];
        wp = cfg_w[k] + 2 * cfg_pad[k];
        n  = hp * wp;
        obs_wr = 0; obs_pad = 0; obs_win = 0; obs_tg = 0; obs_rdy_pad = 0;
        consumed = 0; stalls = 0; done_cyc = 0;
        idx = 0; gap = 0; pend_w = 0; pend_t = 0; cyc = 0; got_done = 0;

        @(negedge clk);
        start_s[k] = 1'b1;
        in_en_s[k] = 1'b0;
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start_s[k] = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            in_en_s[k] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst_at >= 0 && idx == rst_at && gap == 0) begin
                rst = 1'b1;
                start_s[k] = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start_s[k] = 1'b0;
                in_en_s[k] = 1'b0;
                #1;
                check_idle("after_mid_reset", k);
                got_done = 1;
                break;
            end
            #1;
            obs_win += int'(win_s[k]);
            obs_tg  += int'(tg_s[k]);
            if (rdy_s[k] && pad_s[k]) obs_rdy_pad++;
            check("win_valid", k, 32'(win_s[k]), 32'(pend_w));
            check("tg_next",   k, 32'(tg_s[k]),  32'(pend_t));
            check("busy",      k, 32'(busy_s[k]), 1);
            if (idx == n) begin
                check("done_fin",  k, 32'(done_s[k]), 1);
                check("wr_en_fin", k, 32'(wr_s[k]),   0);
                check("frame_cycles", k, cyc, n + cfg_p[k] * (hp - 1) + stalls + 1);
                done_cyc = cyc;
                got_done = 1;
                break;
            end
            check("done", k, 32'(done_s[k]), 0);
            if (gap > 0) begin
                check("gap_wr_en",  k, 32'(wr_s[k]),  0);
                check("gap_in_rdy", k, 32'(rdy_s[k]), 0);
                check("gap_pad",    k, 32'(pad_s[k]), 0);
                pend_w = 0;
                pend_t = 0;
                gap--;
            end else begin
                r   = idx / wp;
                c   = idx % wp;
                pad = (r < cfg_pad[k]) || (r >= cfg_h[k] + cfg_pad[k]) ||
                      (c < cfg_pad[k]) || (c >= cfg_w[k] + cfg_pad[k]);
                wr  = pad || in_en_s[k];
                check("row_cnt",     k, row_of(k),         r);
                check("col_cnt",     k, col_of(k),         c);
                check("pad_mux_sel", k, 32'(pad_s[k]),     32'(pad));
                check("in_rdy",      k, 32'(rdy_s[k]),     32'(!pad));
                check("wr_en",       k, 32'(wr_s[k]),      32'(wr));
                obs_wr  += int'(wr_s[k]);
                obs_pad += int'(wr_s[k] && pad_s[k]);
                if (!pad && in_en_s[k])  consumed++;
                if (!pad && !in_en_s[k]) stalls++;
                if (wr) begin
                    pend_w = (r >= cfg_fh[k] - 1) && (c >= cfg_fw[k] - 1) &&
                             ((r - cfg_fh[k] + 1) % cfg_sh[k] == 0) &&
                             ((c - cfg_fw[k] + 1) % cfg_sw[k] == 0);
                    pend_t = pend_w && (c + cfg_sw[k] > wp - 1);
                    idx++;
                    if (c == wp - 1 && r < hp - 1) gap = cfg_p[k];
                end else begin
                    pend_w = 0;
                    pend_t = 0;
                end
            end
        end
        if (!got_done) check("frame_timeout", k, 0, 1);

        @(negedge clk);
        start_s[k] = 1'b0;
        in_en_s[k] = 1'b0;
        #1;
        check_idle("post_frame", k);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_idle("reset", k);
        @(negedge clk);
        rst = 1'b0;

        // Full padded frame, source always valid.
        run_frame(0, 1'b0, 1'b0, -1);
        check("a_wr_count",   0, obs_wr,   36);
        check("a_pad_count",  0, obs_pad,  20);
        check("a_win_count",  0, obs_win,  16);
        check("a_tg_count",   0, obs_tg,   4);
        check("a_done_cycle", 0, done_cyc, 42);

        // Source stalls plus stray start pulses while busy.
        run_frame(0, 1'b1, 1'b1, -1);
        check("a_stall_consumed", 0, consumed,    16);
        check("a_stall_rdy_pad",  0, obs_rdy_pad, 0);
        check("a_stall_win",      0, obs_win,     16);
        check("a_stall_done",     0, done_cyc,    42 + stalls);

        // Stride 2.
        run_frame(1, 1'b1, 1'b1, -1);
        check("b_win_count", 1, obs_win, 9);
        check("b_tg_count",  1, obs_tg,  3);

        // No padding, no row gap.
        run_frame(2, 1'b0, 1'b0, -1);
        check("c_pad_count",  2, obs_pad,  0);
        check("c_win_count",  2, obs_win,  1);
        check("c_tg_count",   2, obs_tg,   1);
        check("c_done_cycle", 2, done_cyc, 10);

        // Reset at row 2 col 3 (index 15), then start together with reset.
        run_frame(0, 1'b0, 1'b0, 15);
        @(negedge clk);
        rst = 1'b1;
        start_s[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_s[0] = 1'b0;
        #1;
        check_idle("start_with_rst", 0);
        @(negedge clk);
        #1;
        check_idle("start_with_rst_hold", 0);

        // A clean frame afterwards must still be complete.
        run_frame(0, 1'b1, 1'b0, -1);
        check("a_after_rst_win", 0, obs_win, 16);
        check("a_after_rst_tg",  0, obs_tg,  4);
        check("a_after_rst_wr",  0, obs_wr,  36);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
